// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS_32 multicycle control path: opcodes, FSM
// state encoding, datapath mux encodings and the packed control vector.
// ALU_Control imports the ALUOP_* constants from here as well.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REX    = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JMP    = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state + mem_ready -> datapath control vector.
// Anything not set for a state stays 0, so IDLE and TRAP drive nothing.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Per-state control assertions; FETCH/MEMWR are Mealy on mem_ready.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // Only load IR / bump PC in the completing cycle, so a stalled
        // fetch increments the PC exactly once.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = ALUSRCB_IMM_SL2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_REX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALUSRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle main control FSM for the MIPS_32 datapath.
// Optional: define MIPS_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes
// (sticky illegal_op); otherwise unknown opcodes retire as a NOP.
//
// state  | meaning
// IDLE   | post-reset wait, RESET_IDLE_CYCLES cycles
// FETCH  | read instruction at PC, PC+4 on mem_ready
// DECODE | register read, branch target precompute, dispatch
// MEMADR | lw/sw address = A + imm
// MEMRD  | lw memory read, wait for mem_ready
// MEMWB  | lw register writeback from MDR
// MEMWR  | sw memory write, wait for mem_ready
// REX    | R-type execute (funct-driven ALU)
// RWB    | R-type writeback to rd
// BEQ    | compare and conditional PC load
// ADDIEX | addi execute A + imm
// ADDIWB | addi writeback to rt
// JMP    | unconditional jump
// TRAP   | unknown opcode halt, only left by reset
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int RESET_IDLE_CYCLES = 1
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [3:0] IDLE_LAST = 4'(RESET_IDLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic       nop_done;
  ctrl_t      ctrl;

  // The branch decision is made in the datapath (PCWriteCond & zero).
  logic unused_zero;
  assign unused_zero = zero;

  // State register and idle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Next-state logic and opcode dispatch.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    nop_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (idle_cnt_q == IDLE_LAST) state_d = S_FETCH;
        else                         idle_cnt_d = idle_cnt_q + 4'd1;
      end
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_REX;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JMP;
          default: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d  = S_FETCH;
            nop_done = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_REX:    state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_BEQ, S_ADDIWB, S_JMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Sticky flag, set as TRAP is entered so it is high in the first TRAP cycle.
  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // Trap flag register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  mips_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign instr_done  = ctrl.instr_done | nop_done;

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Multicycle main control FSM for the MIPS_32 datapath, directly upstream of ALU_Control. It decodes the 6-bit opcode of the latched instruction, sequences fetch/decode/execute/memory/writeback, and drives every datapath enable/mux select, including the 2-bit ALUOp consumed by ALU_Control. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

Parameters:
- RESET_IDLE_CYCLES, 1, number of cycles spent in IDLE after reset deassertion before the first FETCH (range 1..15).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instruction[31:26] from the instruction register
- zero  input  1  ALU zero flag, for beq
- mem_ready  input  1  memory completes the current access this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by zero (datapath ANDs)
- IorD  output  1  0 = PC address, 1 = ALUOut address
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR
- RegDst  output  1  destination register: 0 = rt, 1 = rd
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0 = PC, 1 = A
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- ALUOp  output  2  00 = add, 01 = sub, 10 = use funct, 11 = reserved (never driven)
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  output  1  sticky unknown-opcode flag (see Optional Feature)

Behaviour:
- Opcodes: R 6'h00, lw 6'h23, sw 6'h2B, beq 6'h04, addi 6'h08, j 6'h02.
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, BEQ, ADDIEX, ADDIWB, JMP, TRAP. Binary encoding is in the package.
- Reset (async, rst_n=0): state=IDLE, idle counter=0, every output 0. No state asserts any output before the first FETCH.
- IDLE: all outputs 0. After RESET_IDLE_CYCLES cycles -> FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite are asserted only in the cycle where mem_ready=1 (Mealy qualification), so the PC increments exactly once. Stays in FETCH while mem_ready=0; -> DECODE on mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode: lw/sw -> MEMADR, R -> REX, beq -> BEQ, addi -> ADDIEX, j -> JMP, other -> see Optional Feature.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Waits for mem_ready, then -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1 -> FETCH.
- MEMWR: MemWrite=1, IorD=1. Waits for mem_ready; instr_done=1 in the ready cycle -> FETCH.
- REX: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1 -> FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1 -> FETCH. Does not depend on zero.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1 -> FETCH.
- JMP: PCWrite=1, PCSource=10, instr_done=1 -> FETCH.
- Any control not listed for a state is 0. Muxes default to 0.
- Latency with mem_ready tied high: R 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- rst_n asserted mid-instruction returns to IDLE immediately. No partial writes after the reset edge.

Optional Feature:
- Macro MIPS_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE -> TRAP. In TRAP all controls are 0 and illegal_op=1 (sticky) until reset.
- Undefined: an unknown opcode is treated as a NOP. DECODE -> FETCH with instr_done=1. TRAP is unreachable and illegal_op is tied 0.

Decomposition:
- Package mips_ctrl_pkg contains the opcode constants, the state encoding, and the ALUOp, ALUSrcB and PCSource encodings. ALU_Control also imports the ALUOp constants from it.
- One natural sub-module: mips_ctrl_decode, a combinational state + mem_ready -> control-vector decoder. The top module holds the state register, idle counter, next-state logic and trap flag.

Test Plan:
- Reset hold with rst_n=0 for 3 cycles, then release -> all outputs 0 during reset and IDLE; FETCH asserts MemRead=1 after 1 IDLE cycle.
- R-type: opcode=6'h00, mem_ready=1 -> states FETCH, DECODE, REX (ALUOp=10), RWB (RegWrite=1, RegDst=1); instr_done on cycle 4.
- lw with mem_ready low for 3 cycles in MEMRD: opcode=6'h23 -> MemRead=1, IorD=1 held 4 cycles. PCWrite pulses exactly once per instruction. MEMWB has MemtoReg=1.
- beq and j: opcode=6'h04 -> BEQ asserts ALUOp=01, PCWriteCond=1, PCSource=01. opcode=6'h02 -> PCWrite=1, PCSource=10. Both take 3 cycles.
- Reset mid-MEMWR: assert rst_n=0 while MemWrite=1 -> MemWrite drops asynchronously and state returns to IDLE.
- opcode=6'h3F with the macro defined -> illegal_op=1, sticky, all controls 0. Without the macro -> returns to FETCH after DECODE with instr_done=1.
